// File: rtl/ahb_frame_addr_gen.sv
// ahb_frame_addr_gen
//   2-D raster address generator for the AHB master (shared by the read and
//   write paths). Walks a frame of `width` rows x `length` bytes starting at
//   `base_addr`. Rows start `pitch` bytes apart. The address advances
//   BEAT_BYTES per accepted beat.
//
// Ports
//   HCLK, HRESETn        clock and asynchronous active-low reset
//   start                begin a frame (only looked at in IDLE)
//   abort                cancel the running frame (only looked at in RUN)
//   base_addr, length,
//   width, pitch         frame geometry, latched on an accepted start
//   addr_update          consumer took the current addr, so advance
//   addr                 current beat address
//   busy                 frame in progress
//   row_last/frame_last  current beat closes its row / the frame
//   done                 one-cycle pulse after the final beat is accepted
//   cfg_err              one-cycle pulse when a start is rejected
//
// state | meaning
// IDLE  | waiting for start; config is checked here
// RUN   | presenting addresses; advances on addr_update
// DONE  | single cycle after the last beat; drives done
module ahb_frame_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = 16,
  parameter int BEAT_BYTES = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  length,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  pitch,
  input  logic              addr_update,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              row_last,
  output logic              frame_last,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DIM_W-1:0]  BEAT_D    = DIM_W'(BEAT_BYTES);
  localparam logic [DIM_W-1:0]  BEAT_MASK = DIM_W'(BEAT_BYTES - 1);
  localparam logic [DIM_W-1:0]  ONE_D     = DIM_W'(1);
  localparam logic [ADDR_W-1:0] BEAT_A    = ADDR_W'(BEAT_BYTES);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  len_q, len_d;
  logic [DIM_W-1:0]  wid_q, wid_d;
  logic [DIM_W-1:0]  pitch_q, pitch_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_bad;
  logic              row_end;
  logic              frame_end;
  logic [ADDR_W-1:0] next_row_base;

  // length must be a whole number of beats; the mask test also covers BEAT_BYTES=1
  assign cfg_bad       = (length == '0) || (width == '0) || ((length & BEAT_MASK) != '0);
  assign row_end       = (col_q == (len_q - BEAT_D));
  assign frame_end     = row_end && (row_q == (wid_q - ONE_D));
  assign next_row_base = row_base_q + ADDR_W'(pitch_q);

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign row_last   = busy && row_end;
  assign frame_last = busy && frame_end;
  assign addr       = addr_q;
  assign cfg_err    = cfg_err_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    len_d      = len_q;
    wid_d      = wid_q;
    pitch_d    = pitch_q;
    cfg_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            len_d      = length;
            wid_d      = width;
            pitch_d    = pitch;
            col_d      = '0;
            row_d      = '0;
            row_base_d = base_addr;
            addr_d     = base_addr;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (addr_update) begin
          if (frame_end) begin
            state_d = ST_DONE;
          end else if (row_end) begin
            col_d      = '0;
            row_d      = row_q + ONE_D;
            row_base_d = next_row_base;
            addr_d     = next_row_base;
          end else begin
            col_d  = col_q + BEAT_D;
            addr_d = addr_q + BEAT_A;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      len_q      <= '0;
      wid_q      <= '0;
      pitch_q    <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      len_q      <= len_d;
      wid_q      <= wid_d;
      pitch_q    <= pitch_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_ahb_frame_addr_gen.sv
module tb_ahb_frame_addr_gen;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start, abort, addr_update;
  logic [31:0] base_addr;
  logic [15:0] length, width, pitch;
  logic [31:0] addr;
  logic        busy, row_last, frame_last, done, cfg_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_addr[$];
  bit          q_rl[$];
  bit          q_fl[$];

  always #5 HCLK = ~HCLK;

  ahb_frame_addr_gen dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .width(width), .pitch(pitch),
    .addr_update(addr_update), .addr(addr), .busy(busy), .row_last(row_last),
    .frame_last(frame_last), .done(done), .cfg_err(cfg_err)
  );

  // Reference beat list for a frame, pushed when the frame is started.
  task automatic push_frame(input logic [31:0] b, input int len, input int wid, input int p);
    for (int r = 0; r < wid; r++) begin
      for (int c = 0; c < len; c += 4) begin
        q_addr.push_back(b + 32'(r * p) + 32'(c));
        q_rl.push_back(c == len - 4);
        q_fl.push_back((c == len - 4) && (r == wid - 1));
      end
    end
  endtask

  task automatic clear_queue;
    q_addr.delete(); q_rl.delete(); q_fl.delete();
  endtask

  task automatic pop_beat;
    void'(q_addr.pop_front()); void'(q_rl.pop_front()); void'(q_fl.pop_front());
  endtask

  // Present one start cycle, then scramble the config inputs to show they are ignored.
  task automatic start_frame(input logic [31:0] b, input logic [15:0] len,
                             input logic [15:0] wid, input logic [15:0] p);
    base_addr = b; length = len; width = wid; pitch = p;
    start = 1'b1; addr_update = 1'b0; abort = 1'b0;
    @(negedge HCLK);
    start = 1'b0;
    base_addr = $urandom; length = 16'($urandom); width = 16'($urandom); pitch = 16'($urandom);
  endtask

  task automatic test_reset;
    HRESETn = 1'b0; start = 0; abort = 0; addr_update = 0;
    base_addr = 0; length = 0; width = 0; pitch = 0;
    repeat (2) @(negedge HCLK);
    total++;
    if ({addr, busy, row_last, frame_last, done, cfg_err} !== 37'd0) begin
      bad++;
      $display("FAIL reset_outputs: addr=%h busy=%b rl=%b fl=%b done=%b err=%b, want all 0",
               addr, busy, row_last, frame_last, done, cfg_err);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_basic;
    clear_queue();
    push_frame(32'h1000, 8, 2, 16);
    start_frame(32'h1000, 16'd8, 16'd2, 16'd16);
    addr_update = 1'b1;
    for (int cyc = 0; cyc < 40 && q_addr.size() > 0; cyc++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || addr !== q_addr[0] ||
          row_last !== q_rl[0] || frame_last !== q_fl[0]) begin
        bad++;
        $display("FAIL basic_beat: addr=%h rl=%b fl=%b busy=%b done=%b, want addr=%h rl=%b fl=%b busy=1 done=0",
                 addr, row_last, frame_last, busy, done, q_addr[0], q_rl[0], q_fl[0]);
      end
      pop_beat();
      @(negedge HCLK);
    end
    total++;
    if (q_addr.size() != 0) begin bad++; $display("FAIL basic_timeout: beats left=%0d, want 0", q_addr.size()); end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || addr !== 32'h1014) begin
      bad++;
      $display("FAIL basic_done: done=%b busy=%b addr=%h, want done=1 busy=0 addr=00001014", done, busy, addr);
    end
    addr_update = 1'b0;
    @(negedge HCLK);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width: done=%b, want 0", done); end
  endtask

  task automatic test_backpressure;
    int busy_cnt = 0;
    clear_queue();
    push_frame(32'h1000, 8, 2, 16);
    start_frame(32'h1000, 16'd8, 16'd2, 16'd16);
    for (int cyc = 0; cyc < 40 && q_addr.size() > 0; cyc++) begin
      addr_update = cyc[0];
      if (busy) busy_cnt++;
      total++;
      if (busy !== 1'b1 || addr !== q_addr[0] || row_last !== q_rl[0] || frame_last !== q_fl[0]) begin
        bad++;
        $display("FAIL bp_beat: addr=%h rl=%b fl=%b busy=%b, want addr=%h rl=%b fl=%b busy=1",
                 addr, row_last, frame_last, busy, q_addr[0], q_rl[0], q_fl[0]);
      end
      if (addr_update) pop_beat();
      @(negedge HCLK);
    end
    addr_update = 1'b0;
    total++;
    if (done !== 1'b1 || busy_cnt != 8) begin
      bad++;
      $display("FAIL bp_done: done=%b busy_cycles=%0d, want done=1 busy_cycles=8", done, busy_cnt);
    end
    @(negedge HCLK);
  endtask

  task automatic test_cfg_err;
    logic [15:0] lens [3] = '{16'd6, 16'd0, 16'd8};
    logic [15:0] wids [3] = '{16'd2, 16'd2, 16'd0};
    for (int i = 0; i < 3; i++) begin
      start_frame(32'h5000, lens[i], wids[i], 16'd16);
      total++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || addr !== 32'h1014) begin
        bad++;
        $display("FAIL cfg_err_%0d: err=%b busy=%b addr=%h, want err=1 busy=0 addr=00001014",
                 i, cfg_err, busy, addr);
      end
      @(negedge HCLK);
      total++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL cfg_err_pulse_%0d: err=%b busy=%b, want 0 0", i, cfg_err, busy);
      end
    end
  endtask

  task automatic test_abort;
    clear_queue();
    push_frame(32'h1000, 8, 2, 16);
    start_frame(32'h1000, 16'd8, 16'd2, 16'd16);
    addr_update = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      total++;
      if (busy !== 1'b1 || addr !== q_addr[0]) begin
        bad++;
        $display("FAIL abort_beat: addr=%h busy=%b, want addr=%h busy=1", addr, busy, q_addr[0]);
      end
      if (cyc == 2) abort = 1'b1; else pop_beat();
      @(negedge HCLK);
    end
    abort = 1'b0; addr_update = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || addr !== 32'h1010) begin
      bad++;
      $display("FAIL abort_idle: busy=%b done=%b addr=%h, want busy=0 done=0 addr=00001010", busy, done, addr);
    end
    @(negedge HCLK);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done: done=%b, want 0", done); end
    clear_queue();
    push_frame(32'h1000, 8, 2, 16);
    start_frame(32'h1000, 16'd8, 16'd2, 16'd16);
    addr_update = 1'b1;
    for (int cyc = 0; cyc < 40 && q_addr.size() > 0; cyc++) begin
      total++;
      if (busy !== 1'b1 || addr !== q_addr[0] || row_last !== q_rl[0] || frame_last !== q_fl[0]) begin
        bad++;
        $display("FAIL restart_beat: addr=%h rl=%b fl=%b, want addr=%h rl=%b fl=%b",
                 addr, row_last, frame_last, q_addr[0], q_rl[0], q_fl[0]);
      end
      pop_beat();
      @(negedge HCLK);
    end
    addr_update = 1'b0;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL restart_done: done=%b, want 1", done); end
    @(negedge HCLK);
  endtask

  // Wrap-around frame, then an overlapping-row frame under random back-pressure.
  task automatic test_wrap_overlap;
    logic [31:0] bases [2] = '{32'hFFFF_FFF8, 32'h0000_2000};
    int          lens  [2] = '{16, 8};
    int          wids  [2] = '{1, 3};
    int          ps    [2] = '{0, 4};
    for (int f = 0; f < 2; f++) begin
      clear_queue();
      push_frame(bases[f], lens[f], wids[f], ps[f]);
      start_frame(bases[f], 16'(lens[f]), 16'(wids[f]), 16'(ps[f]));
      for (int cyc = 0; cyc < 60 && q_addr.size() > 0; cyc++) begin
        addr_update = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        total++;
        if (busy !== 1'b1 || addr !== q_addr[0] || row_last !== q_rl[0] || frame_last !== q_fl[0]) begin
          bad++;
          $display("FAIL frame%0d_beat: addr=%h rl=%b fl=%b busy=%b, want addr=%h rl=%b fl=%b busy=1",
                   f, addr, row_last, frame_last, busy, q_addr[0], q_rl[0], q_fl[0]);
        end
        if (addr_update) pop_beat();
        @(negedge HCLK);
      end
      addr_update = 1'b0;
      total++;
      if (q_addr.size() != 0 || done !== 1'b1) begin
        bad++;
        $display("FAIL frame%0d_done: left=%0d done=%b, want left=0 done=1", f, q_addr.size(), done);
      end
      @(negedge HCLK);
    end
  endtask

  task automatic test_single_and_reset;
    start_frame(32'h3000, 16'd4, 16'd1, 16'd0);
    total++;
    if (busy !== 1'b1 || addr !== 32'h3000 || row_last !== 1'b1 || frame_last !== 1'b1) begin
      bad++;
      $display("FAIL single_first: busy=%b addr=%h rl=%b fl=%b, want 1 00003000 1 1", busy, addr, row_last, frame_last);
    end
    addr_update = 1'b1;
    @(negedge HCLK);
    addr_update = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done: done=%b busy=%b, want 1 0", done, busy);
    end
    @(negedge HCLK);
    start_frame(32'h4000, 16'd16, 16'd4, 16'd32);
    addr_update = 1'b1;
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    total++;
    if ({addr, busy, row_last, frame_last, done, cfg_err} !== 37'd0) begin
      bad++;
      $display("FAIL async_reset: addr=%h busy=%b rl=%b fl=%b done=%b err=%b, want all 0",
               addr, busy, row_last, frame_last, done, cfg_err);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge HCLK);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || addr !== 32'h0) begin
        bad++;
        $display("FAIL post_reset_%0d: done=%b busy=%b addr=%h, want 0 0 00000000", cyc, done, busy, addr);
      end
    end
    addr_update = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_cfg_err();
    test_abort();
    test_wrap_overlap();
    test_single_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
